// File: rtl/shift_arb_ctrl.sv
// Two-requester round-robin controller feeding one WIDTH-bit shift register.
// Granted words are shifted out MSB-first, followed by GAP idle cycles.
module shift_arb_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned GAP   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             ser_src,
    output logic             busy
);

    localparam int unsigned BW = $clog2(WIDTH);
    // GAP=0 never enters S_GAP; keep a 1-bit counter so the vector stays legal.
    localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [GW-1:0]    gcnt_q, gcnt_d;
    logic             ptr_q, ptr_d;
    logic             src_q, src_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             grant;
    logic             idle;

    always_comb begin
        grant      = (req0_valid & req1_valid) ? ptr_q : req1_valid;
        idle       = (state_q == S_IDLE);
        req0_ready = idle & req0_valid & ~grant;
        req1_ready = idle & req1_valid & grant;

        state_d = state_q;
        sreg_d  = sreg_q;
        bcnt_d  = bcnt_q;
        gcnt_d  = gcnt_q;
        ptr_d   = ptr_q;
        src_d   = src_q;

        case (state_q)
            S_IDLE: begin
                if (req0_ready | req1_ready) begin
                    sreg_d  = grant ? req1_data : req0_data;
                    src_d   = grant;
                    bcnt_d  = BW'(WIDTH - 1);
                    ptr_d   = ~grant;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                if (bcnt_q == '0) begin
                    sreg_d = '0;
                    if (GAP > 0) begin
                        state_d = S_GAP;
                        gcnt_d  = GW'(GAP - 1);
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    bcnt_d = bcnt_q - 1'b1;
                end
            end
            S_GAP: begin
                if (gcnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gcnt_d = gcnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        valid_d = (state_d == S_SHIFT);
        last_d  = (state_d == S_SHIFT) && (bcnt_d == '0);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            bcnt_q  <= '0;
            gcnt_q  <= '0;
            ptr_q   <= 1'b0;
            src_q   <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            bcnt_q  <= bcnt_d;
            gcnt_q  <= gcnt_d;
            ptr_q   <= ptr_d;
            src_q   <= src_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    assign ser_out   = sreg_q[WIDTH-1];
    assign ser_valid = valid_q;
    assign ser_last  = last_q;
    assign ser_src   = src_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_shift_arb_ctrl.sv
// Directed bench for shift_arb_ctrl: one instance with GAP=1, one with GAP=0.
module tb_shift_arb_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    always #5 clk = ~clk;

    logic       a_r0v, a_r0r, a_r1v, a_r1r, a_so, a_sv, a_sl, a_ss, a_bz;
    logic [7:0] a_r0d, a_r1d;
    logic       b_r0v, b_r0r, b_r1v, b_r1r, b_so, b_sv, b_sl, b_ss, b_bz;
    logic [7:0] b_r0d, b_r1d;

    int n_checks = 0;
    int n_fail   = 0;

    shift_arb_ctrl #(.WIDTH(8), .GAP(1)) dut (
        .clk(clk), .reset(rst),
        .req0_valid(a_r0v), .req0_data(a_r0d), .req0_ready(a_r0r),
        .req1_valid(a_r1v), .req1_data(a_r1d), .req1_ready(a_r1r),
        .ser_out(a_so), .ser_valid(a_sv), .ser_last(a_sl), .ser_src(a_ss), .busy(a_bz)
    );

    shift_arb_ctrl #(.WIDTH(8), .GAP(0)) dut_g0 (
        .clk(clk), .reset(rst),
        .req0_valid(b_r0v), .req0_data(b_r0d), .req0_ready(b_r0r),
        .req1_valid(b_r1v), .req1_data(b_r1d), .req1_ready(b_r1r),
        .ser_out(b_so), .ser_valid(b_sv), .ser_last(b_sl), .ser_src(b_ss), .busy(b_bz)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        a_r0v = 0; a_r1v = 0; a_r0d = '0; a_r1d = '0;
        b_r0v = 0; b_r1v = 0; b_r0d = '0; b_r1d = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
        #1;
    endtask

    // Called in the first SHIFT cycle; returns in the cycle after the last bit.
    task automatic check_word(input bit sel, input logic src, input logic [7:0] w);
        for (int j = 0; j < 8; j++) begin
            check("ser_valid", sel ? b_sv : a_sv, 1);
            check("ser_out",   sel ? b_so : a_so, w[7-j]);
            check("ser_last",  sel ? b_sl : a_sl, (j == 7));
            check("ser_src",   sel ? b_ss : a_ss, src);
            check("ready_in_shift", sel ? (b_r0r | b_r1r) : (a_r0r | a_r1r), 0);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and single word from req0 (GAP=1)
        clear_inputs();
        rst = 1;
        a_r0v = 1; a_r0d = 8'hA5;
        #1;
        check("rst_busy", a_bz, 0);
        check("rst_valid", a_sv, 0);
        check("rst_out", a_so, 0);
        check("rst_last", a_sl, 0);
        check("rst_src", a_ss, 0);
        check("rst_ready0", a_r0r, 1);
        tick();
        rst = 0;
        #1;
        check("post_rst_ready0", a_r0r, 1);
        tick();
        a_r0v = 0;
        check_word(0, 0, 8'hA5);
        check("gap_busy", a_bz, 1);
        check("gap_valid", a_sv, 0);
        check("gap_out", a_so, 0);
        tick();
        a_r0v = 1;
        #1;
        check("idle_busy", a_bz, 0);
        check("idle_ready0", a_r0r, 1);
        a_r0v = 0;

        // Contention: strict alternation, one word every 10 cycles
        clear_inputs();
        rst = 1;
        a_r0v = 1; a_r0d = 8'hF0; a_r1v = 1; a_r1d = 8'h0F;
        tick();
        rst = 0;
        #1;
        check("cont_ready0_first", a_r0r, 1);
        check("cont_ready1_first", a_r1r, 0);
        tick();
        check_word(0, 0, 8'hF0);
        check("cont_gap_busy", a_bz, 1);
        tick();
        check("cont_ready1_second", a_r1r, 1);
        check("cont_ready0_second", a_r0r, 0);
        tick();
        check_word(0, 1, 8'h0F);
        tick();
        check("cont_ready0_third", a_r0r, 1);
        check("cont_ready1_third", a_r1r, 0);
        tick();
        check_word(0, 0, 8'hF0);
        clear_inputs();

        // Back-to-back lone req1 with GAP=0; data change while shifting ignored
        do_reset();
        b_r1v = 1; b_r1d = 8'h81;
        #1;
        check("b2b_ready1", b_r1r, 1);
        tick();
        b_r1d = 8'h7E;
        check_word(1, 1, 8'h81);
        check("b2b_idle_valid", b_sv, 0);
        check("b2b_idle_busy", b_bz, 0);
        check("b2b_idle_ready1", b_r1r, 1);
        tick();
        b_r1v = 0;
        check_word(1, 1, 8'h7E);
        check("b2b_end_busy", b_bz, 0);

        // Backpressure: req1 waits through SHIFT and GAP; only the handshake data counts
        do_reset();
        a_r0v = 1; a_r0d = 8'h3C;
        tick();
        a_r0v = 0; a_r1v = 1; a_r1d = 8'h11;
        check_word(0, 0, 8'h3C);
        a_r1d = 8'h22;
        #1;
        check("bp_gap_ready1", a_r1r, 0);
        tick();
        a_r1d = 8'h5A;
        #1;
        check("bp_idle_ready1", a_r1r, 1);
        tick();
        a_r1v = 0;
        check_word(0, 1, 8'h5A);

        // Withdrawn request while busy: no grant, pointer stays at req1
        do_reset();
        a_r0v = 1; a_r0d = 8'hC3;
        tick();
        a_r0v = 0;
        tick();
        tick();
        a_r0v = 1;
        #1;
        check("wd_ready0_busy", a_r0r, 0);
        tick();
        a_r0v = 0;
        for (int i = 0; i < 6; i++) tick();
        check("wd_idle_busy", a_bz, 0);
        check("wd_idle_valid", a_sv, 0);
        tick();
        check("wd_still_idle", a_bz, 0);
        a_r0v = 1; a_r1v = 1;
        #1;
        check("wd_ptr_ready1", a_r1r, 1);
        check("wd_ptr_ready0", a_r0r, 0);
        clear_inputs();

        // Reset during bit 3 of 8'hFF, then req0 preferred again
        do_reset();
        a_r0v = 1; a_r0d = 8'hFF;
        tick();
        for (int j = 0; j < 5; j++) begin
            check("mid_bit", a_so, 1);
            if (j < 4) tick();
        end
        #1;
        rst = 1;
        #1;
        check("mid_rst_out", a_so, 0);
        check("mid_rst_valid", a_sv, 0);
        check("mid_rst_busy", a_bz, 0);
        check("mid_rst_last", a_sl, 0);
        check("mid_rst_ready0", a_r0r, 1);
        tick();
        rst = 0;
        a_r1v = 1; a_r1d = 8'h00;
        #1;
        check("after_rst_ready0", a_r0r, 1);
        check("after_rst_ready1", a_r1r, 0);
        tick();
        a_r0v = 0; a_r1v = 0;
        check_word(0, 0, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
